// File: rtl/dat_mem_copy.sv
// Block-copy engine owning the data memory write port: copies len bytes src->dst, one byte per two cycles.
// Optional fill mode (one byte per cycle, constant value) is built only when DAT_MEM_COPY_FILL_EN is defined.
module dat_mem_copy #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [7:0]    len,
  input  logic          fill,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | source byte on mem_addr, captured at the closing edge
  // WRITE | destination byte written from the data register
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t        state;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [7:0]    len_q;
  logic [7:0]    idx;
  logic [7:0]    idx_nxt;

  assign idx_nxt = idx + 8'd1;

`ifdef DAT_MEM_COPY_FILL_EN
  logic fill_q;
`else
  logic unused_fill;
  assign unused_fill = ^{fill, fill_val};
`endif

  // Outputs are registered, so each transition loads the values for the state being entered;
  // mem_dat_in doubles as the data register (and holds the fill byte in fill mode).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_addr   <= '0;
      mem_wr_en  <= 1'b0;
      mem_dat_in <= '0;
`ifdef DAT_MEM_COPY_FILL_EN
      fill_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done       <= 1'b0;
          mem_addr   <= '0;
          mem_wr_en  <= 1'b0;
          mem_dat_in <= '0;
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            len_q <= len;
            idx   <= '0;
            busy  <= 1'b1;
`ifdef DAT_MEM_COPY_FILL_EN
            fill_q <= fill;
`endif
            if (len == 8'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end
`ifdef DAT_MEM_COPY_FILL_EN
            else if (fill) begin
              state      <= WRITE;
              mem_addr   <= dst_addr;
              mem_wr_en  <= 1'b1;
              mem_dat_in <= fill_val;
            end
`endif
            else begin
              state    <= READ;
              mem_addr <= src_addr;
            end
          end
        end
        READ: begin
          state      <= WRITE;
          mem_addr   <= dst_q + AW'(idx);
          mem_wr_en  <= 1'b1;
          mem_dat_in <= mem_dat_out;
        end
        WRITE: begin
          idx <= idx_nxt;
          if (idx_nxt == len_q) begin
            state      <= DONE;
            done       <= 1'b1;
            mem_addr   <= '0;
            mem_wr_en  <= 1'b0;
            mem_dat_in <= '0;
          end
`ifdef DAT_MEM_COPY_FILL_EN
          else if (fill_q) begin
            mem_addr <= dst_q + AW'(idx_nxt);
          end
`endif
          else begin
            state      <= READ;
            mem_addr   <= src_q + AW'(idx_nxt);
            mem_wr_en  <= 1'b0;
            mem_dat_in <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dat_mem_copy.sv
// Directed bench for dat_mem_copy with a 256x8 behavioural memory; fill expectations follow DAT_MEM_COPY_FILL_EN.
module tb_dat_mem_copy;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [7:0] len = '0;
  logic       fill = 1'b0;
  logic [7:0] fill_val = '0;
  logic       busy, done, mem_wr_en;
  logic [7:0] mem_addr, mem_dat_in, mem_dat_out;

  logic [7:0] mem [256];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dat_mem_copy #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .fill(fill), .fill_val(fill_val), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_dat_in(mem_dat_in), .mem_dat_out(mem_dat_out)
  );

  assign mem_dat_out = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_dat_in;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle c is the cycle after edge c-1; edge 0 accepts start. Sampling happens at negedges.
  task automatic run_op(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                        input logic f, input logic [7:0] fv, input int budget,
                        input int pulse_cyc, input int rst_cyc,
                        output int done_cyc, output int done_cnt, output int busy_cnt,
                        output int wr_cnt, output int addr_c1, output int addr_c2, output int post_rst_nz);
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; wr_cnt = 0;
    addr_c1 = -1; addr_c2 = -1; post_rst_nz = -1;
    @(negedge clk);
    src_addr = s; dst_addr = d; len = l; fill = f; fill_val = fv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (busy) busy_cnt++;
      if (mem_wr_en) wr_cnt++;
      if (c == 1) addr_c1 = int'(mem_addr);
      if (c == 2) addr_c2 = int'(mem_addr);
      if (c == pulse_cyc) begin
        src_addr = 8'h00; dst_addr = 8'h60; len = 8'd1; start = 1'b1;
      end
      if (c == pulse_cyc + 1) start = 1'b0;
      if (c == rst_cyc) rst_n = 1'b0;
      if (c == rst_cyc + 1) begin
        post_rst_nz = int'(busy) + int'(done) + int'(mem_wr_en) + int'(mem_addr != 0) + int'(mem_dat_in != 0);
        rst_n = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  int dc, dn, bc, wc, a1, a2, nz;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    mem[8'h60] = 8'hEE;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_dat_in", mem_dat_in, 0);
    rst_n = 1'b1;

    // basic copy 0x10 -> 0x40, len 4
    run_op(8'h10, 8'h40, 8'd4, 1'b0, 8'h00, 12, 0, 0, dc, dn, bc, wc, a1, a2, nz);
    chk("basic_done_cyc", dc, 9);
    chk("basic_done_cnt", dn, 1);
    chk("basic_busy_cnt", bc, 9);
    chk("basic_wr_cnt", wc, 4);
    chk("basic_addr_c1", a1, 8'h10);
    chk("basic_addr_c2", a2, 8'h40);
    chk("basic_m40", mem[8'h40], 8'hAA);
    chk("basic_m41", mem[8'h41], 8'hBB);
    chk("basic_m42", mem[8'h42], 8'hCC);
    chk("basic_m43", mem[8'h43], 8'hDD);

    // source wraps FE,FF,00
    run_op(8'hFE, 8'h80, 8'd3, 1'b0, 8'h00, 10, 0, 0, dc, dn, bc, wc, a1, a2, nz);
    chk("wrap_done_cyc", dc, 7);
    chk("wrap_m80", mem[8'h80], 8'h11);
    chk("wrap_m81", mem[8'h81], 8'h22);
    chk("wrap_m82", mem[8'h82], 8'h33);

    // zero length
    run_op(8'h10, 8'h90, 8'd0, 1'b0, 8'h00, 4, 0, 0, dc, dn, bc, wc, a1, a2, nz);
    chk("len0_done_cyc", dc, 1);
    chk("len0_busy_cnt", bc, 1);
    chk("len0_wr_cnt", wc, 0);

    // start pulse in cycle 3 must be ignored, not queued
    run_op(8'h10, 8'h50, 8'd4, 1'b0, 8'h00, 14, 3, 0, dc, dn, bc, wc, a1, a2, nz);
    chk("busy_start_done_cyc", dc, 9);
    chk("busy_start_done_cnt", dn, 1);
    chk("busy_start_m50", mem[8'h50], 8'hAA);
    chk("busy_start_m53", mem[8'h53], 8'hDD);
    chk("busy_start_m60", mem[8'h60], 8'hEE);

    // reset taking effect at the start of cycle 4 (during the byte-1 read)
    run_op(8'h10, 8'h70, 8'd4, 1'b0, 8'h00, 12, 0, 3, dc, dn, bc, wc, a1, a2, nz);
    chk("midrst_outputs_nz", nz, 0);
    chk("midrst_done_cnt", dn, 0);
    chk("midrst_busy_cnt", bc, 3);
    chk("midrst_m70", mem[8'h70], 8'hAA);
    chk("midrst_m71", mem[8'h71], 8'h00);

    // fill request: real fill when the feature is built, otherwise a plain copy from 0x10
    run_op(8'h10, 8'h20, 8'd3, 1'b1, 8'h5A, 10, 0, 0, dc, dn, bc, wc, a1, a2, nz);
`ifdef DAT_MEM_COPY_FILL_EN
    chk("fill_done_cyc", dc, 4);
    chk("fill_addr_c1", a1, 8'h20);
    chk("fill_m20", mem[8'h20], 8'h5A);
    chk("fill_m21", mem[8'h21], 8'h5A);
    chk("fill_m22", mem[8'h22], 8'h5A);
`else
    chk("nofill_done_cyc", dc, 7);
    chk("nofill_addr_c1", a1, 8'h10);
    chk("nofill_m20", mem[8'h20], 8'hAA);
    chk("nofill_m21", mem[8'h21], 8'hBB);
    chk("nofill_m22", mem[8'h22], 8'hCC);
`endif
    chk("fill_wr_cnt", wc, 3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dat_mem_copy.md
# dat_mem_copy

Block-copy engine sitting directly upstream of the 256×8 data memory and owning its write port, address and write enable. On a start pulse it copies `len` bytes from `src_addr` to `dst_addr` inside that memory, one byte per two cycles, then pulses `done`. Used for data-segment initialisation and bulk moves without processor involvement.

## Interface
- `AW`, 8, address width; memory depth 2^AW
- `DW`, 8, data width
- `clk`  in  1  system clock; all state updates on its rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  request copy; sampled only in IDLE
- `src_addr`  in  AW  first source address; latched on accepted start
- `dst_addr`  in  AW  first destination address; latched on accepted start
- `len`  in  8  byte count, 0..255; latched on accepted start
- `fill`  in  1  fill mode select; functional only with `DAT_MEM_COPY_FILL_EN`
- `fill_val`  in  DW  fill byte; functional only with `DAT_MEM_COPY_FILL_EN`
- `busy`  out  1  high from the cycle after an accepted start until DONE ends
- `done`  out  1  single-cycle completion pulse
- `mem_addr`  out  AW  memory address
- `mem_wr_en`  out  1  memory write enable
- `mem_dat_in`  out  DW  memory write data
- `mem_dat_out`  in  DW  memory read data; combinational from `mem_addr`

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: `start`=1 latches `src_addr`, `dst_addr`, `len` and clears the byte index `idx`. Next state is READ, or DONE if `len`=0.
- READ: `mem_addr`=src+idx. `mem_dat_out` is captured into the data register at the clock edge. Next state is WRITE.
- WRITE: `mem_addr`=dst+idx, `mem_wr_en`=1, `mem_dat_in`=data register. `idx` increments. Next state is READ, or DONE if idx+1==len.
- DONE: `done`=1 for exactly one cycle. Next state is IDLE.
- Address arithmetic is AW-bit modulo 2^AW. src+idx and dst+idx wrap past 0xFF to 0x00.
- Copy order is strictly ascending. Overlapping regions with dst > src produce the ascending-order result; the block does not correct for overlap.
- `start` is ignored in READ, WRITE and DONE. It is not queued.
- In IDLE and DONE: `mem_wr_en`=0, `mem_addr`=0, `mem_dat_in`=0.
- Reset (`rst_n`=0 at an edge), including mid-copy: state goes to IDLE. `busy`, `done`, `mem_wr_en`, `mem_addr`, `mem_dat_in`, `idx` and all latched registers are cleared. Bytes already written stay written.

## Timing
- Reset values of all outputs: 0.
- Edge 0 accepts start. Cycle 1 is the first READ cycle. Each byte takes 2 cycles.
- For `len`=N>0: the last write occurs in cycle 2N. `done` is high in cycle 2N+1. IDLE is reached at edge 2N+2, and a new start is accepted there.
- For `len`=0: `done` is high in cycle 1. No memory access occurs.
- `busy` is high in cycles 1..2N+1 and low in IDLE.
- `mem_wr_en` is high only in WRITE cycles. The memory commits the write at the edge ending that cycle.

## Configuration
- `DAT_MEM_COPY_FILL_EN` defined:
  - An accepted start with `fill`=1 latches `fill_val` and skips READ entirely.
  - State goes IDLE→WRITE. WRITE writes `fill_val` to dst+idx, so each byte takes 1 cycle.
  - `done` is high in cycle N+1.
  - `src_addr` is ignored in fill mode.
- `DAT_MEM_COPY_FILL_EN` undefined:
  - `fill` and `fill_val` are ignored.
  - Every start performs a copy.
  - No fill logic is synthesised.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles. Expect all outputs 0 and state IDLE.
- Basic copy: preload mem[0x10..0x13]=AA,BB,CC,DD; start src=0x10, dst=0x40, len=4. Expect mem[0x40..0x43]=AA,BB,CC,DD, `done` in cycle 9 only, `busy` high in cycles 1..9.
- Wrap and zero length:
  - src=0xFE, dst=0x80, len=3 copies mem[FE],[FF],[00] to 0x80..0x82.
  - len=0 gives `done` in cycle 1 and `mem_wr_en` never high.
- Start while busy: pulse `start` with new args in cycle 3 of a len=4 copy. Expect it ignored and the original copy unchanged.
- Reset mid-copy: assert `rst_n`=0 in cycle 4 of a len=4 copy. Expect only byte 0 written, all outputs 0 next cycle, and no `done`.
- Fill (macro defined): start fill=1, fill_val=0x5A, dst=0x20, len=3. Expect mem[0x20..0x22]=5A, no READ cycles, `done` in cycle 4.
- Fill (macro undefined): same stimulus performs a copy instead.
